rtc_counter: RTL and testbench
==============================

RTC_COUNTER -- requirements
Module: rtc_counter

Interface
REQ-001 SHALL have parameter CE_PER_SEC, default 4000000, giving the number of clk_ce-qualified cycles per RTC second.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clk_ce, input, 1 bit: clock enable; state SHALL change only on clk edges with clk_ce=1, except on reset.
REQ-005 SHALL have port bus_write, input, 1 bit: CPU write strobe.
REQ-006 SHALL have port bus_address_in, input, 24 bits: CPU address.
REQ-007 SHALL have port bus_data_in, input, 8 bits: CPU write data.
REQ-008 SHALL have port bus_data_out, output, 8 bits: combinational register read data.
REQ-009 SHALL have port rtc_load, input, 1 bit: host request to restore a saved count (level; host holds it high until it sees validate_rtc).
REQ-010 SHALL have port rtc_load_value, input, 24 bits: count to restore; stable while rtc_load=1.
REQ-011 SHALL have port validate_rtc, output, 1 bit: one-clk_ce-cycle pulse marking a restored count valid; it drives the system control register block.
REQ-012 SHALL have port rtc_tick, output, 1 bit: one-clk_ce-cycle pulse on each seconds increment.

Function
REQ-013 SHALL implement these registers:
- 0x2008 CTRL: bit0 RUN (read/write); bit1 CLEAR (write-1 action, reads 0); bits7:2 read 0.
- 0x2009/0x200A/0x200B: seconds count bits 7:0/15:8/23:16, read-only.
REQ-014 bus_data_out SHALL return the addressed register for 0x2008-0x200B and 0x00 for any other address, with no latency.
REQ-015 Bus writes SHALL be latched: bus_write=1 on a clk_ce cycle SHALL take effect on the next clk_ce cycle, using bus_address_in and bus_data_in as sampled on that next cycle.
REQ-016 Writes to 0x2009-0x200B SHALL be ignored.
REQ-017 The prescaler SHALL have width ceil(log2(CE_PER_SEC)) and SHALL advance by 1 on every clk_ce cycle with RUN=1.
- On reaching CE_PER_SEC-1 it SHALL return to 0, increment the count by 1 and pulse rtc_tick on that same cycle.
REQ-018 The 24-bit count SHALL wrap from 0xFFFFFF to 0x000000.
REQ-019 With RUN=0, the prescaler and count SHALL hold their values.
REQ-020 A latched CLEAR write SHALL zero the count and prescaler, suppress any tick on that cycle, and apply RUN from the same write.
REQ-021 Load FSM states SHALL be IDLE, LOAD, VALID, WAIT.
- IDLE->LOAD when rtc_load=1.
- LOAD: count<=rtc_load_value and prescaler<=0, then ->VALID.
- VALID: validate_rtc=1 for exactly one clk_ce cycle, then ->WAIT.
- WAIT->IDLE when rtc_load=0.
REQ-022 A held rtc_load SHALL produce exactly one validate_rtc pulse.
REQ-023 Priority on one clk_ce cycle SHALL be CLEAR > LOAD > tick increment; a suppressed tick SHALL NOT pulse rtc_tick.
REQ-024 validate_rtc and rtc_tick SHALL be registered outputs that are high only on clk_ce cycles; when clk_ce=0 they SHALL hold their value.

Reset
REQ-025 Asserting reset SHALL asynchronously force count=0, prescaler=0, RUN=0, the write latch=0, FSM=IDLE, validate_rtc=0 and rtc_tick=0.
REQ-026 A reset asserted mid-load SHALL abandon the load with no validate_rtc pulse; after release, a still-high rtc_load SHALL start a fresh load.
REQ-027 bus_data_out SHALL read 0x00 at all four RTC addresses after reset.

Verification (CE_PER_SEC=4, clk_ce=1 unless stated)
REQ-028 Write 0x01 to 0x2008, then run 12 cycles -> count=3, exactly three rtc_tick pulses spaced 4 cycles apart.
REQ-029 rtc_load_value=0xFFFFFE with rtc_load held 10 cycles, RUN=1 -> single validate_rtc pulse, count reads 0xFFFFFE, then 0xFFFFFF, then 0x000000 on successive ticks.
REQ-030 Write 0x03 to 0x2008 while count=0x000010 -> count=0, RUN=1, 0x2008 reads 0x01, next tick arrives 4 cycles later.
REQ-031 Latched CLEAR on the same cycle as LOAD and a prescaler rollover -> count=0, no rtc_tick; load completes and validate_rtc pulses one cycle later.
REQ-032 clk_ce toggling 1-of-3 with RUN=1 -> one tick per 12 clk, and pulses held across clk_ce=0 cycles.
REQ-033 Reset asserted while FSM is in LOAD -> outputs 0 immediately, no validate_rtc; read 0x200B -> 0x00; read 0x2010 -> 0x00.

Source files
------------

// File: rtl/rtc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_counter
//  Purpose  : Real-time-clock seconds counter with CPU register interface and
//             a host-driven restore (load) handshake.
//
//             A prescaler divides clk_ce-qualified cycles down to one-second
//             ticks that advance a 24-bit seconds count. The CPU controls
//             RUN/CLEAR through a control register. The host can restore a
//             saved count through the rtc_load / validate_rtc handshake.
//
//  Ports    :
//    clk            in   1   single rising-edge clock
//    reset          in   1   asynchronous active-low reset
//    clk_ce         in   1   clock enable qualifying every state change
//    bus_write      in   1   CPU write strobe (latched, applied next clk_ce)
//    bus_address_in in  24   CPU address
//    bus_data_in    in   8   CPU write data
//    bus_data_out   out  8   combinational read data
//    rtc_load       in   1   host restore request (level)
//    rtc_load_value in  24   count to restore
//    validate_rtc   out  1   one-clk_ce-cycle pulse: restored count valid
//    rtc_tick       out  1   one-clk_ce-cycle pulse per seconds increment
//
//  Register map:
//    0x2008 CTRL  bit0 RUN (r/w), bit1 CLEAR (write-1 action, reads 0)
//    0x2009       count[7:0]   (read-only)
//    0x200A       count[15:8]  (read-only)
//    0x200B       count[23:16] (read-only)
//
//  Revision : 1.0  initial release
// ============================================================================
module rtc_counter #(
    parameter int CE_PER_SEC = 4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic        rtc_load,
    input  logic [23:0] rtc_load_value,
    output logic        validate_rtc,
    output logic        rtc_tick
);

    // Prescaler width; a divide-by-1 configuration still needs one bit.
    localparam int PS_W = (CE_PER_SEC > 1) ? $clog2(CE_PER_SEC) : 1;

    localparam logic [PS_W-1:0] c_PS_LAST   = PS_W'(CE_PER_SEC - 1);
    localparam logic [23:0]     c_ADDR_CTRL = 24'h002008;
    localparam logic [23:0]     c_ADDR_CNT0 = 24'h002009;
    localparam logic [23:0]     c_ADDR_CNT1 = 24'h00200A;
    localparam logic [23:0]     c_ADDR_CNT2 = 24'h00200B;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_VALID = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_run;
    logic              r_wr_pend;
    logic              r_validate;
    logic              r_tick;
    logic [23:0]       r_count;
    logic [PS_W-1:0]   r_presc;

    logic              w_wr_ctrl;
    logic              w_clear;
    logic              w_load;
    logic              w_rollover;
    logic              w_unused_data;

    // A write strobe is remembered for one clk_ce cycle; the address and
    // data seen on the following clk_ce cycle are the ones that take effect.
    assign w_wr_ctrl  = r_wr_pend && (bus_address_in == c_ADDR_CTRL);
    assign w_clear    = w_wr_ctrl && bus_data_in[1];
    assign w_load     = (r_state == S_LOAD);
    assign w_rollover = r_run && (r_presc == c_PS_LAST);

    // Upper control bits carry no function.
    assign w_unused_data = ^bus_data_in[7:2];

    // ------------------------------------------------------------------
    // Control register, prescaler and seconds count.
    // CLEAR beats LOAD beats the tick increment; a CLEAR or LOAD on a
    // rollover cycle swallows that tick entirely (no rtc_tick pulse).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_pend <= 1'b0;
            r_run     <= 1'b0;
            r_count   <= 24'd0;
            r_presc   <= '0;
            r_tick    <= 1'b0;
        end else if (clk_ce) begin
            r_wr_pend <= bus_write;
            r_tick    <= 1'b0;

            if (w_wr_ctrl) begin
                r_run <= bus_data_in[0];
            end

            if (w_clear) begin
                r_count <= 24'd0;
                r_presc <= '0;
            end else if (w_load) begin
                r_count <= rtc_load_value;
                r_presc <= '0;
            end else if (r_run) begin
                if (w_rollover) begin
                    r_presc <= '0;
                    r_count <= r_count + 24'd1;  // wraps 0xFFFFFF -> 0
                    r_tick  <= 1'b1;
                end else begin
                    r_presc <= r_presc + PS_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Restore handshake. validate_rtc is raised on the edge that leaves
    // LOAD, so it is high exactly while the FSM sits in VALID. WAIT holds
    // off a second load until the host drops rtc_load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_validate <= 1'b0;
        end else if (clk_ce) begin
            r_validate <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rtc_load) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_VALID;
                    r_validate <= 1'b1;
                end
                S_VALID: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!rtc_load) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register read mux (zero latency).
    // ------------------------------------------------------------------
    always_comb begin
        bus_data_out = 8'h00;
        case (bus_address_in)
            c_ADDR_CTRL: bus_data_out = {7'd0, r_run};
            c_ADDR_CNT0: bus_data_out = r_count[7:0];
            c_ADDR_CNT1: bus_data_out = r_count[15:8];
            c_ADDR_CNT2: bus_data_out = r_count[23:16];
            default:     bus_data_out = 8'h00;
        endcase
    end

    assign validate_rtc = r_validate;
    assign rtc_tick     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_rtc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_counter
//  Purpose  : Self-checking bench for rtc_counter (CE_PER_SEC = 4).
//             Stimulus runs on falling edges; per-edge expectations for
//             rtc_tick / validate_rtc are queued ahead of time and popped by
//             a monitor shortly after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtc_counter;

    logic        clk;
    logic        reset;
    logic        clk_ce;
    logic        bus_write;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        rtc_load;
    logic [23:0] rtc_load_value;
    logic        validate_rtc;
    logic        rtc_tick;

    int n_checks = 0;
    int n_errors = 0;
    int mon_idx  = 0;

    typedef struct packed {
        logic tick;
        logic val;
    } exp_t;

    exp_t q_exp[$];
    exp_t m_e;

    rtc_counter #(
        .CE_PER_SEC (4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce         (clk_ce),
        .bus_write      (bus_write),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .rtc_load       (rtc_load),
        .rtc_load_value (rtc_load_value),
        .validate_rtc   (validate_rtc),
        .rtc_tick       (rtc_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic t, input logic v);
        exp_t e;
        e.tick = t;
        e.val  = v;
        q_exp.push_back(e);
    endtask

    task automatic rd(input logic [23:0] a, input logic [7:0] e, input string tag);
        bus_address_in = a;
        #1;
        check_eq(tag, 32'(bus_data_out), 32'(e));
    endtask

    // Starts just after a falling edge; returns on the falling edge after
    // the rising edge at which the write takes effect.
    task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
        bus_write      = 1'b1;
        bus_address_in = a;
        bus_data_in    = d;
        @(negedge clk);
        bus_write = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard consumer: one queued expectation per rising edge.
    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            m_e = q_exp.pop_front();
            mon_idx++;
            check_eq($sformatf("tick[%0d]", mon_idx), 32'(rtc_tick), 32'(m_e.tick));
            check_eq($sformatf("validate[%0d]", mon_idx), 32'(validate_rtc), 32'(m_e.val));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: sim time exceeded, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        clk_ce         = 1'b1;
        bus_write      = 1'b0;
        bus_address_in = 24'h0;
        bus_data_in    = 8'h00;
        rtc_load       = 1'b0;
        rtc_load_value = 24'h0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_tick", 32'(rtc_tick), 32'd0);
        check_eq("rst_valid", 32'(validate_rtc), 32'd0);
        rd(24'h002008, 8'h00, "rst_ctrl");
        rd(24'h002009, 8'h00, "rst_cnt0");
        rd(24'h00200A, 8'h00, "rst_cnt1");
        rd(24'h00200B, 8'h00, "rst_cnt2");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- RUN: 12 cycles -> 3 ticks ----------------
        bus_wr(24'h002008, 8'h01);
        for (int k = 1; k <= 12; k++) push_exp((k % 4) == 0, 1'b0);
        repeat (12) @(negedge clk);
        rd(24'h002009, 8'h03, "run_cnt0");
        rd(24'h002008, 8'h01, "run_ctrl");
        rd(24'h002010, 8'h00, "run_other");

        // ---------------- load near wrap ----------------
        bus_wr(24'h002008, 8'h02);          // clear, RUN=0
        rtc_load_value = 24'hFFFFFE;
        rtc_load       = 1'b1;
        for (int k = 1; k <= 10; k++) push_exp(1'b0, k == 2);
        repeat (10) @(negedge clk);
        rd(24'h002009, 8'hFE, "ld_cnt0");
        rd(24'h00200A, 8'hFF, "ld_cnt1");
        rd(24'h00200B, 8'hFF, "ld_cnt2");
        rtc_load = 1'b0;
        bus_wr(24'h002008, 8'h01);
        for (int k = 1; k <= 8; k++) push_exp((k % 4) == 0, 1'b0);
        repeat (4) @(negedge clk);
        rd(24'h002009, 8'hFF, "wrap1_cnt0");
        rd(24'h00200B, 8'hFF, "wrap1_cnt2");
        repeat (4) @(negedge clk);
        rd(24'h002009, 8'h00, "wrap2_cnt0");
        rd(24'h00200B, 8'h00, "wrap2_cnt2");

        // ---------------- CLEAR with RUN from count 0x10 ----------------
        rtc_load_value = 24'h000010;
        rtc_load       = 1'b1;
        repeat (2) @(negedge clk);
        rd(24'h002009, 8'h10, "clr_pre_cnt0");
        rtc_load = 1'b0;
        bus_wr(24'h002008, 8'h03);
        rd(24'h002008, 8'h01, "clr_ctrl");
        rd(24'h002009, 8'h00, "clr_cnt0");
        for (int k = 1; k <= 4; k++) push_exp(k == 4, 1'b0);
        repeat (4) @(negedge clk);
        rd(24'h002009, 8'h01, "clr_post_cnt0");

        // ------- CLEAR + LOAD + prescaler rollover on one edge -------
        repeat (2) @(negedge clk);          // prescaler now 2
        rtc_load_value = 24'h5A5A5A;
        rtc_load       = 1'b1;
        bus_write      = 1'b1;
        bus_address_in = 24'h002008;
        bus_data_in    = 8'h03;
        for (int k = 1; k <= 6; k++) push_exp(k == 6, k == 2);
        @(negedge clk);
        bus_write = 1'b0;
        @(negedge clk);
        rd(24'h002009, 8'h00, "prio_cnt0");
        rd(24'h00200B, 8'h00, "prio_cnt2");
        rd(24'h002008, 8'h01, "prio_ctrl");
        rtc_load = 1'b0;
        repeat (4) @(negedge clk);
        rd(24'h002009, 8'h01, "prio_post_cnt0");

        // ---------------- clk_ce 1-of-3 ----------------
        bus_wr(24'h002008, 8'h03);
        for (int j = 1; j <= 26; j++)
            push_exp(((j >= 10) && (j <= 12)) || ((j >= 22) && (j <= 24)), 1'b0);
        for (int j = 1; j <= 26; j++) begin
            clk_ce = ((j % 3) == 1);
            @(negedge clk);
        end
        clk_ce = 1'b1;
        rd(24'h002009, 8'h02, "ce_cnt0");

        // ---------------- reset mid-load ----------------
        rtc_load_value = 24'h123456;
        rtc_load       = 1'b1;
        @(negedge clk);                     // FSM now in LOAD
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(validate_rtc), 32'd0);
        check_eq("mid_rst_tick", 32'(rtc_tick), 32'd0);
        rd(24'h00200B, 8'h00, "mid_rst_cnt2");
        rd(24'h002009, 8'h00, "mid_rst_cnt0");
        rd(24'h002008, 8'h00, "mid_rst_ctrl");
        rd(24'h002010, 8'h00, "mid_rst_other");
        for (int k = 1; k <= 3; k++) push_exp(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) push_exp(1'b0, k == 2);
        repeat (4) @(negedge clk);
        rd(24'h00200B, 8'h12, "reload_cnt2");
        rd(24'h00200A, 8'h34, "reload_cnt1");
        rd(24'h002009, 8'h56, "reload_cnt0");
        rtc_load = 1'b0;

        // ---------------- writes to count registers ignored ----------------
        bus_wr(24'h002009, 8'hFF);
        rd(24'h002009, 8'h56, "ro_cnt0");
        bus_wr(24'h00200B, 8'h00);
        rd(24'h00200B, 8'h12, "ro_cnt2");

        // ---------------- scoreboard drained ----------------
        for (int i = 0; i < 50 && q_exp.size() > 0; i++) @(negedge clk);
        check_eq("sb_drain", 32'(q_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
